restoring_divider: RTL and testbench
====================================

# restoring_divider

Sequential unsigned integer divider, the inverse companion of the shift-add multiplier. It uses the same start/ready handshake as the multiplier so that a sequencer can drive either unit interchangeably. Internally it is a restoring shift-subtract datapath under a small controller. It produces one quotient bit per clock and presents a registered quotient and remainder when `ready` is high.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.

- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division. Sampled on the rising edge only in IDLE or DONE.
- `dividend`  in  WIDTH: unsigned dividend. Sampled on the accepting edge only.
- `divisor`  in  WIDTH: unsigned divisor. Sampled on the accepting edge only.
- `ready`  out  1: high in DONE. Result outputs are valid while high.
- `busy`  out  1: high in SHIFT.
- `quotient`  out  WIDTH: registered quotient.
- `remainder`  out  WIDTH: registered remainder.
- `divide_by_zero`  out  1: registered flag for the last accepted operation.

## Operation
- States:
  - IDLE: after reset.
  - SHIFT: iterating.
  - DONE: result held.
- Reset value of all outputs is 0, with state IDLE. `ready` stays 0 until the first completed operation.
- Accepting edge: the rising edge where the state is IDLE or DONE, `start`=1 and `reset`=0.
  - If `divisor` ≠ 0: load the partial remainder R (WIDTH+1 bits) = 0, the quotient shift register Q = `dividend`, the divisor register D = `divisor`, and the iteration counter = WIDTH−1. Go to SHIFT.
  - If `divisor` = 0: go directly to DONE.
    - `quotient` = all ones.
    - `remainder` = `dividend`.
    - `divide_by_zero` = 1.
  - `ready` falls on the accepting edge.
- SHIFT step, one per edge:
  - {R,Q} is shifted left 1. The MSB of Q enters the LSB of R.
  - The trial value is T = R − {1'b0, D}, computed WIDTH+2 bits wide.
  - If T ≥ 0: R = T[WIDTH:0] and Q[0] = 1. Otherwise R is unchanged (restored) and Q[0] = 0.
  - The counter decrements.
- On the step edge where the counter is 0:
  - Go to DONE.
  - `quotient` = the new Q.
  - `remainder` = the new R[WIDTH−1:0].
  - `divide_by_zero` = 0.
- In DONE:
  - `ready` = 1 and all outputs hold.
  - `start`=1 starts a new operation (back-to-back issue allowed). `start`=0 stays in DONE.
- `start` in SHIFT is ignored. `dividend` and `divisor` may change freely during SHIFT without affecting the result.
- `quotient`, `remainder` and `divide_by_zero` keep the previous result throughout SHIFT. They update only on the edge entering DONE.
- Reset mid-operation: the next edge with `reset`=1 returns to IDLE and clears all outputs. This applies in any state and takes priority over `start`.
- Invariant: when `ready` is high and `divide_by_zero`=0, `dividend` = `quotient`·`divisor` + `remainder` and `remainder` < `divisor`, for the operands captured.

## Timing
- Latency: with accepting edge E0 and a nonzero divisor, `ready`=1 after edge E0+WIDTH. That is WIDTH SHIFT cycles.
- With a zero divisor, `ready`=1 after edge E0+1.
- `busy`=1 from after E0 until the edge entering DONE. `ready` and `busy` are never both 1.
- All outputs are registered, with no combinational path from inputs to outputs.
- Throughput with `start` held high: one result every WIDTH+1 cycles. `ready` is high for exactly one cycle between operations.

## Test plan
- Reset then idle: hold `reset`=1 for 2 edges, release, wait 3 edges → all outputs 0, `ready`=0, `busy`=0.
- WIDTH=8, 100/7, `start` pulsed one cycle → `busy` high for 8 cycles, `ready`=1 after edge E0+8, `quotient`=14, `remainder`=2, `divide_by_zero`=0; outputs still held 5 cycles later.
- Boundary operands, each run back-to-back with `start` held high:
  - 255/1 → `quotient`=255, `remainder`=0.
  - 5/9 → `quotient`=0, `remainder`=5.
  - 255/255 → `quotient`=1, `remainder`=0.
  - 0/3 → `quotient`=0, `remainder`=0.
  - Between results, `ready` is low for exactly 8 cycles.
- Divide by zero, 200/0 → `ready`=1 after E0+1, `quotient`=255, `remainder`=200, `divide_by_zero`=1. A subsequent 9/4 gives 2 r 1 with `divide_by_zero`=0.
- Busy interference: start 100/7; at cycle 3 pulse `start` with operands 50/5 and also change `dividend`/`divisor` → result still 14 r 2 at E0+8, no second operation begins.
- Reset mid-operation: start 100/7, assert `reset` at cycle 4 → next edge gives IDLE with all outputs 0. A new 60/7 then completes as 8 r 4 at its E0+8.

Source files
------------

// File: rtl/restoring_divider_if.sv
// restoring_divider_if
//   Handshake and operand/result bundle for the restoring divider.
//   master : drives start, dividend and divisor, and observes the results
//   slave  : the divider itself
//   Signals:
//     start          request a division
//     dividend       unsigned dividend, WIDTH bits
//     divisor        unsigned divisor, WIDTH bits
//     ready          result valid (DONE)
//     busy           iterating (SHIFT)
//     quotient       registered quotient, WIDTH bits
//     remainder      registered remainder, WIDTH bits
//     divide_by_zero registered flag for the last accepted operation
interface restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divide_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, quotient, remainder, divide_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, quotient, remainder, divide_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Shares the start/ready handshake of the shift-add multiplier.
//   Ports:
//     clock  single clock, rising edge
//     reset  synchronous, active-high; returns to IDLE and clears outputs
//     bus    restoring_divider_if.slave (start, operands, ready, busy,
//            quotient, remainder, divide_by_zero)
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input logic                clock,
    input logic                reset,
    restoring_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   rem_r;      // partial remainder R
    logic [WIDTH-1:0] quo_r;      // quotient shift register Q
    logic [WIDTH-1:0] div_r;      // captured divisor D
    logic [CW-1:0]    cnt;
    // Set when DONE was entered from a zero divisor: ready rises one edge
    // later so that path still has a one-cycle latency after the accept.
    logic             zero_pend;

    logic [WIDTH+1:0] shifted;    // {R,Q[MSB]} after the left shift
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // R < D always holds between steps, so R's top bit is zero and the
    // shifted value fits the WIDTH+2 bit trial without loss.
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        trial   = shifted - {2'b00, div_r};
        rem_nxt = shifted[WIDTH:0];
        quo_nxt = {quo_r[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_nxt = trial[WIDTH:0];
            quo_nxt = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            rem_r              <= '0;
            quo_r              <= '0;
            div_r              <= '0;
            cnt                <= '0;
            zero_pend          <= 1'b0;
            bus.ready          <= 1'b0;
            bus.busy           <= 1'b0;
            bus.quotient       <= '0;
            bus.remainder      <= '0;
            bus.divide_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && zero_pend) begin
                        bus.ready <= 1'b1;
                        zero_pend <= 1'b0;
                    end else if (bus.start) begin
                        bus.ready <= 1'b0;
                        if (bus.divisor != '0) begin
                            rem_r    <= '0;
                            quo_r    <= bus.dividend;
                            div_r    <= bus.divisor;
                            cnt      <= CW'(WIDTH - 1);
                            bus.busy <= 1'b1;
                            state    <= SHIFT;
                        end else begin
                            bus.quotient       <= '1;
                            bus.remainder      <= bus.dividend;
                            bus.divide_by_zero <= 1'b1;
                            zero_pend          <= 1'b1;
                            state              <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bus.quotient       <= quo_nxt;
                        bus.remainder      <= rem_nxt[WIDTH-1:0];
                        bus.divide_by_zero <= 1'b0;
                        bus.busy           <= 1'b0;
                        bus.ready          <= 1'b1;
                        state              <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    restoring_divider_if #(.WIDTH(W)) bus();
    restoring_divider #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           e0;
        int           lat;
        int           gap;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every rising edge of ready.
    logic prev_rdy = 1'b0;
    int   low_cnt  = 0;
    always @(negedge clock) begin
        exp_t e;
        chk("ready_busy_exclusive", {31'b0, bus.ready & bus.busy}, 0);
        if (bus.ready && !prev_rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got q=%0d r=%0d with nothing pending, want no result",
                         bus.quotient, bus.remainder);
            end else begin
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("divide_by_zero", bus.divide_by_zero, e.z);
                chk("latency", cyc - e.e0, e.lat);
                if (e.gap >= 0) chk("ready_low_gap", low_cnt, e.gap);
            end
            low_cnt = 0;
        end else if (!bus.ready) begin
            low_cnt++;
        end
        prev_rdy = bus.ready;
    end

    // Present operands with start high and wait until the result edge;
    // start stays high so consecutive calls issue back-to-back.
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int gap);
        exp_t e;
        int   lat;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        lat   = (dv == 0) ? 1 : W;
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.e0  = cyc + 1;
        e.lat = lat;
        e.gap = gap;
        sb.push_back(e);
        @(posedge clock);
        repeat (lat) @(posedge clock);
    endtask

    initial begin
        exp_t e;
        int   bc;
        int   w;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset then idle
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.divide_by_zero, 0);

        // 100/7 with a single-cycle start pulse
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        e.q = 8'd14; e.r = 8'd2; e.z = 1'b0; e.e0 = cyc + 1; e.lat = W; e.gap = -1;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) bc++;
            @(negedge clock);
        end
        chk("busy_cycles", bc, W);
        repeat (5) @(negedge clock);
        chk("hold_ready", bus.ready, 1);
        chk("hold_quotient", bus.quotient, 14);
        chk("hold_remainder", bus.remainder, 2);
        chk("hold_dbz", bus.divide_by_zero, 0);

        // Boundary operands, back-to-back
        issue(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, -1);
        issue(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, W);
        issue(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, W);
        issue(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, W);
        @(negedge clock) bus.start = 1'b0;
        repeat (3) @(negedge clock);

        // Divide by zero followed by a normal division
        issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, -1);
        issue(8'd9,   8'd4, 8'd2,   8'd1,   1'b0, -1);
        @(negedge clock) bus.start = 1'b0;
        repeat (3) @(negedge clock);

        // start and operand changes while busy are ignored
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        e.q = 8'd14; e.r = 8'd2; e.z = 1'b0; e.e0 = cyc + 1; e.lat = W; e.gap = -1;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock) bus.start = 1'b0;
        repeat (2) @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.dividend = 8'd33;
        bus.divisor  = 8'd0;
        repeat (20) @(negedge clock);
        chk("interf_ready", bus.ready, 1);
        chk("interf_quotient", bus.quotient, 14);
        chk("interf_remainder", bus.remainder, 2);

        // Reset mid-operation
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clock);
        @(negedge clock) bus.start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_ready", bus.ready, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_dbz", bus.divide_by_zero, 0);
        reset = 1'b0;
        issue(8'd60, 8'd7, 8'd8, 8'd4, 1'b0, -1);
        @(negedge clock) bus.start = 1'b0;

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clock);
            w++;
        end
        repeat (5) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
